// File: rtl/module_packed_lane_arbiter_if.sv
// Bundle of request/grant, PA and packed-word handshake signals for
// module_packed_lane_arbiter.
//   master : producer/consumer side (drives requests, data, flush, ready)
//   slave  : arbiter side (drives grants, packed word, PA entries, pa_update)
// Parameter PV_LANES sets the width of data_out_pv (8*PV_LANES).
interface module_packed_lane_arbiter_if #(
  parameter int PV_LANES = 4
);
  logic                    enable_pv;
  logic                    req_pv;
  logic [7:0]              data_in_pv;
  logic                    gnt_pv;
  logic                    req_pa;
  logic [15:0]             data_in_pa;
  logic                    gnt_pa;
  logic                    flush_pv;
  logic                    word_valid_pv;
  logic                    word_ready_pv;
  logic [8*PV_LANES-1:0]   data_out_pv;
  logic [7:0]              data_out_pa;
  logic [7:0]              data_out_pa_hi;
  logic                    pa_update;

  modport master (
    output enable_pv, req_pv, data_in_pv, req_pa, data_in_pa, flush_pv,
           word_ready_pv,
    input  gnt_pv, gnt_pa, word_valid_pv, data_out_pv, data_out_pa,
           data_out_pa_hi, pa_update
  );

  modport slave (
    input  enable_pv, req_pv, data_in_pv, req_pa, data_in_pa, flush_pv,
           word_ready_pv,
    output gnt_pv, gnt_pa, word_valid_pv, data_out_pv, data_out_pa,
           data_out_pa_hi, pa_update
  );
endinterface

// File: rtl/module_packed_lane_arbiter.sv
// Round-robin arbiter sharing one packing resource between a PV byte stream
// (packed lane-by-lane into a PV_LANES x 8-bit word with valid/ready output)
// and a PA halfword (split into two byte entries).
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - module_packed_lane_arbiter_if.slave: requests/grants, flush,
//          packed-word handshake, PA entries and pa_update pulse
// Optional feature macro: PACKED_INVERT_LANE_EN (odd lanes store ~data_in_pv).
module module_packed_lane_arbiter #(
  parameter int PV_LANES = 4
) (
  input logic clk,
  input logic rst,
  module_packed_lane_arbiter_if.slave bus
);
  localparam int CNT_W = (PV_LANES > 1) ? $clog2(PV_LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PV_LANES - 1);

  logic [7:0]       lane_reg [PV_LANES];
  logic [7:0]       lane_in  [PV_LANES];
  logic [CNT_W-1:0] cnt_reg;
  logic             word_valid_reg;
  logic             ptr_reg;        // 0: PV preferred, 1: PA preferred
  logic [7:0]       pa_lo_reg;
  logic [7:0]       pa_hi_reg;
  logic             pa_update_reg;

  logic elig_pv, elig_pa, gnt_pv, gnt_pa;
  logic handshake, flush_eff, pv_write, clear_lanes;

  assign elig_pv = bus.req_pv & bus.enable_pv & ~word_valid_reg;
  assign elig_pa = bus.req_pa & bus.enable_pv;
  // On contention the side not granted most recently wins.
  assign gnt_pv  = elig_pv & (~elig_pa | ~ptr_reg);
  assign gnt_pa  = elig_pa & (~elig_pv |  ptr_reg);

  assign handshake   = word_valid_reg & bus.word_ready_pv;
  // Flush only acts on a partial word; a completed word is never discarded.
  assign flush_eff   = bus.flush_pv & ~word_valid_reg;
  // A flushed cycle still reports the grant, but the byte is dropped.
  assign pv_write    = gnt_pv & ~flush_eff;
  assign clear_lanes = handshake | flush_eff;

  assign bus.gnt_pv         = gnt_pv;
  assign bus.gnt_pa         = gnt_pa;
  assign bus.word_valid_pv  = word_valid_reg;
  assign bus.data_out_pa    = pa_lo_reg;
  assign bus.data_out_pa_hi = pa_hi_reg;
  assign bus.pa_update      = pa_update_reg;

  generate
    for (genvar gi = 0; gi < PV_LANES; gi++) begin : g_lane
`ifdef PACKED_INVERT_LANE_EN
      if ((gi % 2) == 1) begin : g_inv
        assign lane_in[gi] = ~bus.data_in_pv;
      end else begin : g_pass
        assign lane_in[gi] = bus.data_in_pv;
      end
`else
      assign lane_in[gi] = bus.data_in_pv;
`endif

      always_ff @(posedge clk) begin
        if (rst || clear_lanes) begin
          lane_reg[gi] <= 8'h00;
        end else if (pv_write && (cnt_reg == CNT_W'(gi))) begin
          lane_reg[gi] <= lane_in[gi];
        end
      end

      assign bus.data_out_pv[8*gi +: 8] = lane_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      word_valid_reg <= 1'b0;
      ptr_reg        <= 1'b0;
      pa_lo_reg      <= 8'h00;
      pa_hi_reg      <= 8'h00;
      pa_update_reg  <= 1'b0;
    end else begin
      pa_update_reg <= gnt_pa;

      if (gnt_pa) begin
        pa_lo_reg <= bus.data_in_pa[7:0];
        pa_hi_reg <= bus.data_in_pa[15:8];
      end

      // Pointer follows grants only, so disabled cycles leave it untouched.
      if (gnt_pv) begin
        ptr_reg <= 1'b1;
      end else if (gnt_pa) begin
        ptr_reg <= 1'b0;
      end

      if (handshake) begin
        word_valid_reg <= 1'b0;
      end else if (flush_eff) begin
        cnt_reg <= '0;
      end else if (pv_write) begin
        if (cnt_reg == LAST_LANE) begin
          cnt_reg        <= '0;
          word_valid_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end
endmodule
